// File: rtl/mtx_pkg.sv
// Shared types and defaults for the mtx datapath stages.
package mtx_pkg;

    // Ingress arbiter state: free to arbitrate, or holding a grant mid-packet.
    typedef enum logic {
        MTX_ARB_IDLE   = 1'b0,
        MTX_ARB_LOCKED = 1'b1
    } mtx_arb_state_t;

    // Default geometry, shared with mtx_top.
    localparam int MTX_NUM_CH     = 32;
    localparam int MTX_DATA_WIDTH = 32;

    // Width of a channel index; a single channel still needs a 1-bit tag.
    function automatic int mtx_id_width(input int num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

endpackage

// File: rtl/mtx_rr_arb.sv
// Combinational rotating-priority encoder: returns the first set request
// found scanning upward from rr_ptr, wrapping from NUM_REQ-1 back to 0.
module mtx_rr_arb
    import mtx_pkg::*;
#(
    parameter int  NUM_REQ   = MTX_NUM_CH,
    localparam int IDX_WIDTH = mtx_id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] rr_ptr,
    output logic [IDX_WIDTH-1:0] winner,
    output logic                 any
);

    // One extra bit so ptr + offset never overflows before the wrap.
    localparam int SUM_W = IDX_WIDTH + 1;

    logic [IDX_WIDTH-1:0] ptr_s;
    logic [SUM_W-1:0]     sum_s;
    logic [IDX_WIDTH-1:0] idx_s;
    logic [IDX_WIDTH-1:0] winner_s;
    logic                 any_s;

    // An out-of-range pointer (only possible for non-power-of-2 sizes) restarts at 0.
    assign ptr_s = (SUM_W'(rr_ptr) < SUM_W'(NUM_REQ)) ? rr_ptr : {IDX_WIDTH{1'b0}};

    // Scan offsets 0..NUM_REQ-1 from the pointer; the first hit wins.
    always_comb begin
        winner_s = {IDX_WIDTH{1'b0}};
        any_s    = 1'b0;
        sum_s    = {SUM_W{1'b0}};
        idx_s    = {IDX_WIDTH{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_s    = SUM_W'(ptr_s) + SUM_W'(k);
            sum_s    = (sum_s >= SUM_W'(NUM_REQ)) ? (sum_s - SUM_W'(NUM_REQ)) : sum_s;
            idx_s    = sum_s[IDX_WIDTH-1:0];
            winner_s = (req[idx_s] && !any_s) ? idx_s : winner_s;
            any_s    = any_s | req[idx_s];
        end
    end

    assign winner = winner_s;
    assign any    = any_s;

endmodule

// File: rtl/mtx_ingress_arb.sv
// Packet-locked round-robin ingress arbiter feeding mtx_top. Merges NUM_CH
// valid/ready packet streams into one registered, channel-tagged stream.
module mtx_ingress_arb
    import mtx_pkg::*;
#(
    parameter int  NUM_CH      = MTX_NUM_CH,
    parameter int  DATA_WIDTH  = MTX_DATA_WIDTH,
    localparam int CH_ID_WIDTH = mtx_id_width(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_ID_WIDTH-1:0]       out_ch,
    output logic                         out_last,
    output logic                         busy
);

    mtx_arb_state_t         state_r;
    mtx_arb_state_t         state_nxt_s;
    logic [CH_ID_WIDTH-1:0] lock_ch_r;
    logic [CH_ID_WIDTH-1:0] lock_ch_nxt_s;
    logic [CH_ID_WIDTH-1:0] rr_ptr_r;
    logic [CH_ID_WIDTH-1:0] rr_ptr_nxt_s;
    logic [CH_ID_WIDTH-1:0] win_s;
    logic [CH_ID_WIDTH-1:0] sel_s;
    logic [CH_ID_WIDTH-1:0] next_ptr_s;
    logic [NUM_CH-1:0]      cand_s;
    logic [NUM_CH-1:0]      in_ready_s;
    logic [DATA_WIDTH-1:0]  sel_data_s;
    logic                   sel_valid_s;
    logic                   sel_last_s;
    logic                   any_s;
    logic                   locked_s;
    logic                   can_load_s;
    logic                   grant_ok_s;
    logic                   accept_s;
    logic                   out_valid_nxt_s;

    logic                   out_valid_r;
    logic [DATA_WIDTH-1:0]  out_data_r;
    logic [CH_ID_WIDTH-1:0] out_ch_r;
    logic                   out_last_r;
    logic                   busy_r;

    // Only enabled channels with a beat pending compete in IDLE.
    assign cand_s = in_valid & ch_enable;

    mtx_rr_arb #(
        .NUM_REQ (NUM_CH)
    ) u_rr_arb (
        .req    (cand_s),
        .rr_ptr (rr_ptr_r),
        .winner (win_s),
        .any    (any_s)
    );

    assign locked_s   = (state_r == MTX_ARB_LOCKED);
    assign sel_s      = locked_s ? lock_ch_r : win_s;
    assign can_load_s = !out_valid_r || out_ready;
    // A held grant offers ready even through a bubble on the locked channel.
    assign grant_ok_s = !reset && can_load_s && (locked_s || any_s);
    assign accept_s   = grant_ok_s && sel_valid_s;
    assign next_ptr_s = (sel_s == CH_ID_WIDTH'(NUM_CH - 1)) ? {CH_ID_WIDTH{1'b0}}
                                                             : (sel_s + CH_ID_WIDTH'(1));
    assign out_valid_nxt_s = accept_s || (out_valid_r && !out_ready);

    // Steer the selected channel's beat and drive its one-hot ready.
    always_comb begin
        sel_data_s  = {DATA_WIDTH{1'b0}};
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        in_ready_s  = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_s == CH_ID_WIDTH'(i)) begin
                sel_data_s    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid_s   = in_valid[i];
                sel_last_s    = in_last[i];
                in_ready_s[i] = grant_ok_s;
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    // Next-state logic: lock on a non-last beat, release and rotate on last.
    always_comb begin
        state_nxt_s   = state_r;
        lock_ch_nxt_s = lock_ch_r;
        rr_ptr_nxt_s  = rr_ptr_r;
        case (state_r)
            MTX_ARB_IDLE: begin
                if (accept_s && !sel_last_s) begin
                    state_nxt_s   = MTX_ARB_LOCKED;
                    lock_ch_nxt_s = sel_s;
                end else if (accept_s) begin
                    rr_ptr_nxt_s  = next_ptr_s;
                end else begin
                    state_nxt_s   = MTX_ARB_IDLE;
                end
            end
            MTX_ARB_LOCKED: begin
                if (accept_s && sel_last_s) begin
                    state_nxt_s  = MTX_ARB_IDLE;
                    rr_ptr_nxt_s = next_ptr_s;
                end else begin
                    state_nxt_s  = MTX_ARB_LOCKED;
                end
            end
            default: begin
                state_nxt_s = MTX_ARB_IDLE;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= MTX_ARB_IDLE;
            lock_ch_r <= {CH_ID_WIDTH{1'b0}};
            rr_ptr_r  <= {CH_ID_WIDTH{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            lock_ch_r <= lock_ch_nxt_s;
            rr_ptr_r  <= rr_ptr_nxt_s;
        end
    end

    // Output register: load on accept, drop valid once drained, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_ch_r    <= {CH_ID_WIDTH{1'b0}};
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            out_valid_r <= out_valid_nxt_s;
            busy_r      <= (state_nxt_s == MTX_ARB_LOCKED) || out_valid_nxt_s;
            if (accept_s) begin
                out_data_r <= sel_data_s;
                out_ch_r   <= sel_s;
                out_last_r <= sel_last_s;
            end else begin
                out_data_r <= out_data_r;
                out_ch_r   <= out_ch_r;
                out_last_r <= out_last_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mtx_ingress_arb.sv
// Randomized scoreboard bench for mtx_ingress_arb against a behavioural model.
module tb_mtx_ingress_arb;

    localparam int NUM_CH = 32;
    localparam int DW     = 32;
    localparam int IDW    = 5;

    logic                 clk;
    logic                 reset;
    logic [NUM_CH-1:0]    ch_enable;
    logic [NUM_CH-1:0]    in_valid;
    logic [NUM_CH-1:0]    in_ready;
    logic [NUM_CH*DW-1:0] in_data;
    logic [NUM_CH-1:0]    in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic [IDW-1:0]       out_ch;
    logic                 out_last;
    logic                 busy;

    mtx_ingress_arb #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ch_enable (ch_enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .busy      (busy)
    );

    typedef struct packed {
        logic [DW-1:0]  d;
        logic [IDW-1:0] ch;
        logic           last;
    } beat_t;

    // Upstream sources: each entry is {last, data}.
    logic [DW:0] src_q [NUM_CH][$];
    beat_t       sb [$];

    int total = 0;
    int bad   = 0;
    int seq   = 0;

    // Stimulus knobs.
    bit                rst_v       = 1'b1;
    logic [NUM_CH-1:0] en_v        = '1;
    int                ordy_pct    = 100;
    int                ordy_low    = 0;
    int                bubble_pct  = 0;
    bit                done        = 1'b0;

    // Reference model state (spec-level: who holds the grant, where rotation resumes).
    bit locked_m = 1'b0;
    int lock_m   = 0;
    int ptr_m    = 0;
    bit ov_m     = 1'b0;
    bit prev_rst = 1'b0;
    bit just_rst = 1'b0;
    int acc_cnt [NUM_CH];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int ch, input int len);
        for (int b = 0; b < len; b++) begin
            src_q[ch].push_back({(b == len - 1), 8'(ch), 24'(seq)});
            seq++;
        end
    endtask

    // One clock: drive inputs on the falling edge, then check and advance the model.
    task automatic step();
        logic [NUM_CH-1:0] cand;
        logic [NUM_CH-1:0] rdy_m;
        logic [DW:0]       bt;
        beat_t             e;
        int                sel;
        bit                have;
        bit                can_load;
        @(negedge clk);
        reset     = rst_v;
        ch_enable = en_v;
        if (ordy_low > 0) begin
            out_ready = 1'b0;
            ordy_low--;
        end else begin
            out_ready = (ordy_pct >= 100) ? 1'b1 : ($urandom_range(99) < ordy_pct);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (src_q[i].size() > 0 &&
                !(bubble_pct > 0 && $urandom_range(99) < bubble_pct)) begin
                in_valid[i]          = 1'b1;
                in_data[i*DW +: DW]  = src_q[i][0][DW-1:0];
                in_last[i]           = src_q[i][0][DW];
            end else begin
                in_valid[i]          = 1'b0;
                in_data[i*DW +: DW]  = '0;
                in_last[i]           = 1'b0;
            end
        end
        #1;
        if (reset) begin
            chk("ready_in_reset", in_ready, 64'd0);
            if (prev_rst) chk("valid_in_reset", out_valid, 64'd0);
            locked_m = 1'b0; lock_m = 0; ptr_m = 0; ov_m = 1'b0;
            sb.delete();
            prev_rst = 1'b1;
            just_rst = 1'b1;
        end else begin
            if (just_rst) begin
                chk("rst_out_valid", out_valid, 64'd0);
                chk("rst_out_data", out_data, 64'd0);
                chk("rst_out_ch", out_ch, 64'd0);
                chk("rst_out_last", out_last, 64'd0);
                chk("rst_busy", busy, 64'd0);
            end
            just_rst = 1'b0;
            prev_rst = 1'b0;
            chk("out_valid", out_valid, ov_m);
            chk("busy", busy, locked_m || ov_m);
            cand = in_valid & ch_enable;
            have = 1'b0;
            sel  = 0;
            if (locked_m) begin
                have = 1'b1;
                sel  = lock_m;
            end else begin
                for (int k = 0; k < NUM_CH; k++) begin
                    int c = (ptr_m + k) % NUM_CH;
                    if (!have && cand[c]) begin
                        have = 1'b1;
                        sel  = c;
                    end
                end
            end
            can_load = !ov_m || out_ready;
            rdy_m = '0;
            if (have && can_load) rdy_m[sel] = 1'b1;
            chk("in_ready", in_ready, rdy_m);
            if (have && can_load && in_valid[sel]) begin
                bt     = src_q[sel].pop_front();
                e.d    = bt[DW-1:0];
                e.ch   = sel[IDW-1:0];
                e.last = bt[DW];
                sb.push_back(e);
                acc_cnt[sel]++;
                if (bt[DW]) begin
                    locked_m = 1'b0;
                    ptr_m    = (sel + 1) % NUM_CH;
                end else begin
                    locked_m = 1'b1;
                    lock_m   = sel;
                end
                ov_m = 1'b1;
            end else if (ov_m && out_ready) begin
                ov_m = 1'b0;
            end
        end
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < NUM_CH; i++) if (src_q[i].size() != 0) return 1'b0;
        return (sb.size() == 0);
    endfunction

    task automatic drain(input string name, input int max);
        for (int n = 0; n < max; n++) begin
            if (all_idle()) break;
            step();
        end
        total++;
        if (!all_idle()) begin
            bad++;
            $display("FAIL drain_%s: got pending beats expected none after %0d cycles", name, max);
        end
    endtask

    task automatic wait_acc(input string name, input int ch, input int target, input int max);
        for (int n = 0; n < max; n++) begin
            if (acc_cnt[ch] >= target) break;
            step();
        end
        total++;
        if (acc_cnt[ch] < target) begin
            bad++;
            $display("FAIL wait_%s: got %0d beats expected %0d", name, acc_cnt[ch], target);
        end
    endtask

    // Monitor: whenever a beat is presented, compare it with the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (done) break;
            if (!reset && out_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got ch %0d data %0h expected no beat", out_ch, out_data);
                end else begin
                    chk("out_data", out_data, sb[0].d);
                    chk("out_ch", out_ch, sb[0].ch);
                    chk("out_last", out_last, sb[0].last);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int base;
        reset = 1'b1; out_ready = 1'b1; ch_enable = '1;
        in_valid = '0; in_data = '0; in_last = '0;
        for (int i = 0; i < NUM_CH; i++) acc_cnt[i] = 0;

        // Reset release: every channel requesting while reset is held.
        for (int i = 0; i < NUM_CH; i++) push_pkt(i, 1);
        rst_v = 1'b1;
        repeat (3) step();
        rst_v = 1'b0;
        drain("reset_release", 200);

        // Fairness: 3, 7, 31 single-beat packets back to back.
        for (int r = 0; r < 6; r++) begin
            push_pkt(3, 1); push_pkt(7, 1); push_pkt(31, 1);
        end
        drain("fairness", 200);

        // Packet lock: 4-beat packet 0xA0..0xA3 on ch5 while ch6 keeps asking.
        for (int b = 0; b < 4; b++) src_q[5].push_back({(b == 3), 32'hA0 + 32'(b)});
        for (int r = 0; r < 3; r++) push_pkt(6, 2);
        drain("lock", 200);

        // Backpressure: stall 3 cycles mid-packet, then random backpressure.
        push_pkt(1, 5); push_pkt(20, 3);
        step(); step();
        ordy_low = 3;
        drain("bp_fixed", 200);
        ordy_pct = 60;
        push_pkt(12, 6); push_pkt(13, 4); push_pkt(0, 3);
        drain("bp_random", 400);
        ordy_pct = 100;

        // Masking: disable ch2 mid-packet; it finishes, then waits for re-enable.
        base = acc_cnt[2];
        push_pkt(2, 4);
        wait_acc("mask_lock", 2, base + 1, 50);
        en_v[2] = 1'b0;
        push_pkt(2, 2);
        push_pkt(4, 3); push_pkt(4, 3);
        repeat (25) step();
        en_v = '1;
        drain("mask", 200);

        // Reset mid-packet on ch9, then a fresh packet must arrive intact.
        base = acc_cnt[9];
        push_pkt(9, 5);
        wait_acc("rst_mid", 9, base + 2, 50);
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        src_q[9].delete();
        push_pkt(9, 5);
        drain("rst_mid", 200);

        // Random traffic with bubbles, backpressure and mask changes.
        bubble_pct = 20;
        ordy_pct   = 70;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(2) == 0) begin
                int c = $urandom_range(NUM_CH - 1);
                if (src_q[c].size() < 8) push_pkt(c, $urandom_range(4, 1));
            end
            if ($urandom_range(39) == 0) en_v = NUM_CH'($urandom);
            step();
        end
        en_v = '1; bubble_pct = 0; ordy_pct = 100;
        drain("random", 3000);

        done = 1'b1;
        repeat (2) @(negedge clk);
        chk("sb_leftover", sb.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
